// File: rtl/bram_asym_clr.sv
// Mixed-width simple-dual-port RAM with read-valid, optional output register and a row-sweeping clear engine.
// Read latency 1 cycle (OUT_REG=0) or 2 (OUT_REG=1); both ports stall (ready low) for ROWS cycles while a sweep runs.
module bram_asym_clr #(
  parameter int          READ_WIDTH       = 64,
  parameter int          READ_ADDR_WIDTH  = 9,
  parameter int          WRITE_WIDTH      = 32,
  parameter int          WRITE_ADDR_WIDTH = 10,
  parameter int          OUT_REG          = 0,
  parameter logic [63:0] CLEAR_VALUE      = 64'd0,
  parameter int          CLEAR_ON_RESET   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_start,
  output logic                        clr_busy,
  input  logic                        r_valid,
  output logic                        r_ready,
  input  logic [READ_ADDR_WIDTH-1:0]  r_addr,
  output logic [READ_WIDTH-1:0]       r_data,
  output logic                        r_data_valid,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [WRITE_ADDR_WIDTH-1:0] w_addr,
  input  logic [WRITE_WIDTH-1:0]      w_data
);

  localparam int MIN_W     = (READ_WIDTH < WRITE_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
  localparam int MAX_W     = (READ_WIDTH < WRITE_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
  localparam int RATIO     = MAX_W / MIN_W;
  localparam int L         = $clog2(RATIO);
  localparam int LW        = (L > 0) ? L : 1;
  localparam bit RD_NARROW = READ_WIDTH < WRITE_WIDTH;
  localparam bit WR_NARROW = WRITE_WIDTH < READ_WIDTH;
  localparam int ROW_AW    = WR_NARROW ? READ_ADDR_WIDTH : WRITE_ADDR_WIDTH;
  localparam int ROWS      = 2 ** ROW_AW;
  localparam int WREP      = MAX_W / WRITE_WIDTH;

  localparam logic [MIN_W-1:0] CLR_LANE = CLEAR_VALUE[MIN_W-1:0];
  localparam logic [MAX_W-1:0] CLR_ROW  = {RATIO{CLR_LANE}};

  generate
    if ((MAX_W % MIN_W) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_err_ratio
      $error("bram_asym_clr: width ratio must be a power of two");
    end
    if (READ_WIDTH * (2 ** READ_ADDR_WIDTH) != WRITE_WIDTH * (2 ** WRITE_ADDR_WIDTH)) begin : g_err_size
      $error("bram_asym_clr: read and write port capacities differ");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [MAX_W-1:0] mem [ROWS];

  state_t            r_state, w_state_nxt;
  logic [ROW_AW-1:0] r_cnt, w_cnt_nxt;
  logic              r_auto;
  logic              w_busy;

  assign w_busy   = (r_state == ST_CLEAR);
  assign clr_busy = w_busy;
  assign r_ready  = !w_busy;
  assign w_ready  = !w_busy;

  // r_auto stands in for clr_start on the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_auto  <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_auto  <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_start || r_auto) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == ROW_AW'(ROWS - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [ROW_AW-1:0] w_wr_row;
  logic [RATIO-1:0]  w_wr_be;
  logic [MAX_W-1:0]  w_wr_dat;

  generate
    if (WR_NARROW) begin : g_wr_narrow
      assign w_wr_row = w_addr[WRITE_ADDR_WIDTH-1:L];
      always_comb begin
        w_wr_be = '0;
        w_wr_be[w_addr[L-1:0]] = 1'b1;
      end
    end else begin : g_wr_wide
      assign w_wr_row = w_addr;
      assign w_wr_be  = '1;
    end
  endgenerate

  assign w_wr_dat = {WREP{w_data}};

  logic [RATIO-1:0]  w_mem_we;
  logic [ROW_AW-1:0] w_mem_row;
  logic [MAX_W-1:0]  w_mem_dat;

  // The sweep owns the write port outright; user writes are dropped while busy
  always_comb begin
    w_mem_we  = '0;
    w_mem_row = w_wr_row;
    w_mem_dat = w_wr_dat;
    if (w_busy) begin
      w_mem_we  = '1;
      w_mem_row = r_cnt;
      w_mem_dat = CLR_ROW;
    end else if (w_valid) begin
      w_mem_we = w_wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RATIO; i++) begin
      if (w_mem_we[i]) mem[w_mem_row][i*MIN_W +: MIN_W] <= w_mem_dat[i*MIN_W +: MIN_W];
    end
  end

  logic [MAX_W-1:0]      w_rd_row_word;
  logic [READ_WIDTH-1:0] w_rd_word;
  logic                  w_rd_acc;

  generate
    if (RD_NARROW) begin : g_rd_narrow
      logic [LW-1:0] w_rd_lane;
      assign w_rd_lane     = r_addr[L-1:0];
      assign w_rd_row_word = mem[r_addr[READ_ADDR_WIDTH-1:L]];
      assign w_rd_word     = w_rd_row_word[w_rd_lane*MIN_W +: MIN_W];
    end else begin : g_rd_wide
      assign w_rd_row_word = mem[r_addr];
      assign w_rd_word     = w_rd_row_word;
    end
  endgenerate

  assign w_rd_acc = r_valid && !w_busy;

  logic [READ_WIDTH-1:0] r_s1_dat;
  logic                  r_s1_vld;

  // Array is sampled before this edge's write lands, giving read-first behaviour
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_dat <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) r_s1_dat <= w_rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [READ_WIDTH-1:0] r_s2_dat;
      logic                  r_s2_vld;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s2_dat <= '0;
          r_s2_vld <= 1'b0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) r_s2_dat <= r_s1_dat;
        end
      end
      assign r_data       = r_s2_dat;
      assign r_data_valid = r_s2_vld;
    end else begin : g_no_out_reg
      assign r_data       = r_s1_dat;
      assign r_data_valid = r_s1_vld;
    end
  endgenerate

endmodule
